serial_add_ctrl: RTL and testbench

Bit-serial N-bit adder/subtractor sequencer built around one instance of the 1-bit full adder `sum_comp` (x, y, z in → s, c out).
- Latches operands on a start handshake.
- Feeds one bit pair per clock, LSB first, through the full adder and holds the carry in a flop between cycles.
- Collects sum bits into a shift register and publishes a stable result with a done pulse.
- Gives the CPU datapath a small-area ALU add path where latency is acceptable.

---
 rtl/serial_add_pkg.sv | 14 +
 rtl/sum_comp.sv | 14 +
 rtl/serial_add_ctrl.sv | 96 +++++++++
 tb/tb_serial_add_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared constants for the bit-serial adder/subtractor sequencer.
// FSM state encoding and legal WIDTH bounds.
package serial_add_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/sum_comp.sv
// One-bit full adder used as the serial adder's single arithmetic cell.
// Purely combinational.
module sum_comp (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic s,
    output logic c
);

    assign s = x ^ y ^ z;
    assign c = (x & y) | (z & (x ^ y));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial N-bit add/subtract sequencer, LSB first, one bit per clock.
// Define SERIAL_ADD_OVF_EN to add the registered signed-overflow output ovf.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_s;
    logic             fa_c;

    sum_comp u_fa (
        .x (op_a[0]),
        .y (op_b[0]),
        .z (carry),
        .s (fa_s),
        .c (fa_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub | cin;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    res   <= {fa_s, res[WIDTH-1:1]};
                    carry <= fa_c;
                    cnt   <= cnt + 1'b1;
                    // Last bit: publish the completed word together with its carry.
                    if (cnt == CNT_LAST) begin
                        sum   <= {fa_s, res[WIDTH-1:1]};
                        cout  <= fa_c;
`ifdef SERIAL_ADD_OVF_EN
                        ovf   <= carry ^ fa_c;
`endif
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign ready = (state == ST_IDLE);
    assign busy  = (state == ST_RUN);
    assign done  = (state == ST_DONE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized self-checking bench for serial_add_ctrl (WIDTH=8, 50 ns clock).
// Expected results come from plain integer arithmetic on the operands.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] last_sum  = '0;
    logic         last_cout = 1'b0;
    logic         last_ovf  = 1'b0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #25 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".ready"}, 32'(ready), 32'd1);
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".done"}, 32'(done), 32'd0);
        check({tag, ".sum"}, 32'(sum), 32'(last_sum));
        check({tag, ".cout"}, 32'(cout), 32'(last_cout));
`ifdef SERIAL_ADD_OVF_EN
        check({tag, ".ovf"}, 32'(ovf), 32'(last_ovf));
`endif
    endtask

    // Runs one operation from an idle negedge; perturb scribbles on inputs during RUN.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tc, input logic ts, input bit perturb);
        logic [W:0]   full;
        logic [W-1:0] opb;
        logic         exp_ovf;
        int           busy_cnt;
        bit           seen;
        bit           moved;
        int           dones;

        opb     = ts ? ~tb_ : tb_;
        full    = {1'b0, ta} + {1'b0, opb} + (W+1)'(ts | tc);
        exp_ovf = (ta[W-1] == opb[W-1]) && (full[W-1] != ta[W-1]);

        a = ta; b = tb_; cin = tc; sub = ts; start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        busy_cnt = 0;
        seen     = 0;
        moved    = 0;
        dones    = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done) begin
                seen = 1;
                dones++;
            end else begin
                if (busy) busy_cnt++;
                if (sum !== last_sum || cout !== last_cout) moved = 1;
            end
            if (perturb && !seen) begin
                start = 1'($urandom);
                a     = W'($urandom);
                b     = W'($urandom);
                cin   = 1'($urandom);
                sub   = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            if (!seen) @(negedge clk);
        end
        check("done_seen", 32'(seen), 32'd1);
        check("busy_cycles", 32'(busy_cnt), 32'(W));
        check("sum_held_during_run", 32'(moved), 32'd0);
        check("sum", 32'(sum), 32'(full[W-1:0]));
        check("cout", 32'(cout), 32'(full[W]));
`ifdef SERIAL_ADD_OVF_EN
        check("ovf", 32'(ovf), 32'(exp_ovf));
`endif
        last_sum  = full[W-1:0];
        last_cout = full[W];
        last_ovf  = exp_ovf;
        @(negedge clk);
        if (done) dones++;
        check("single_done", 32'(dones), 32'd1);
        check_idle_outputs("post_op");
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; sub = 1'b0;
        a = '0; b = '0; cin = 1'b0;

        repeat (2) @(negedge clk);
        check_idle_outputs("in_reset");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle_outputs("idle_no_start");
        end

        run_op(8'h0F, 8'h01, 1'b0, 1'b0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 0);
        run_op(8'h05, 8'h07, 1'b0, 1'b1, 0);
        run_op(8'h80, 8'h01, 1'b0, 1'b1, 0);
        run_op(8'h12, 8'h34, 1'b0, 1'b0, 1);

        // Abort: reset lands mid-RUN, between clock edges.
        a = 8'h5A; b = 8'h3C; cin = 1'b1; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'd1);
        #5 rst_n = 1'b0;
        #1;
        last_sum = '0; last_cout = 1'b0; last_ovf = 1'b0;
        check_idle_outputs("abort_reset");
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int d = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (done) d++;
            end
            check("abort_no_done", 32'(d), 32'd0);
        end
        check_idle_outputs("after_abort");
        run_op(8'h03, 8'h04, 1'b0, 1'b0, 0);

        for (int i = 0; i < 30; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                   bit'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                check_idle_outputs("gap");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
